// File: rtl/pipe_fetch_ctrl.sv
// Fetch-stage controller: PC register, IF/ID register and interrupt FSM.
// Interrupts are taken only when ID has no control transfer in flight.
module pipe_fetch_ctrl #(
    parameter logic [31:0] VECTOR   = 32'h0000_0008,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic [31:0] ins,
    input  logic        intr,
    input  logic        inten,
    input  logic        eret,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] dinst,
    output logic        dvalid,
    output logic [31:0] epc,
    output logic        inta,
    output logic        busy
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        TAKE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        req;
    logic        quiet;
    logic        take;
    logic [31:0] pc4;
    logic [31:0] pcsel;

    logic [31:0] pc_nx;
    logic [31:0] epc_nx;
    logic [31:0] dpc4_nx;
    logic [31:0] dinst_nx;
    logic        dvalid_nx;

    assign req   = intr & inten;
    assign quiet = ~stall & (pcsource == 2'b00) & ~eret;
    assign take  = (state == TAKE);
    assign pc4   = pc + 32'h4;

    assign inta  = take;
    assign busy  = (state != RUN);

    // Next-PC source selected by ID.
    always_comb begin
        pcsel = pc4;
        unique case (pcsource)
            2'b00: pcsel = pc4;
            2'b01: pcsel = bpc;
            2'b10: pcsel = rpc;
            2'b11: pcsel = jpc;
            default: pcsel = pc4;
        endcase
    end

    // Interrupt FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Interrupt FSM next state: wait in PEND for a quiet ID stage.
    always_comb begin
        state_nx = state;
        unique case (state)
            RUN: begin
                if (req) state_nx = PEND;
            end
            PEND: begin
                if (!req)       state_nx = RUN;
                else if (quiet) state_nx = TAKE;
            end
            TAKE: begin
                state_nx = RUN;
            end
            default: begin
                state_nx = RUN;
            end
        endcase
    end

    // Next PC / IF/ID / epc: take > stall > eret > normal fetch.
    always_comb begin
        pc_nx     = pc;
        epc_nx    = epc;
        dpc4_nx   = dpc4;
        dinst_nx  = dinst;
        dvalid_nx = dvalid;
        unique case (1'b1)
            take: begin
                pc_nx     = VECTOR;
                epc_nx    = pc;
                dpc4_nx   = 32'h0;
                dinst_nx  = 32'h0;
                dvalid_nx = 1'b0;
            end
            (!take && stall): begin
                pc_nx = pc;
            end
            (!take && !stall && eret): begin
                pc_nx     = epc;
                dpc4_nx   = 32'h0;
                dinst_nx  = 32'h0;
                dvalid_nx = 1'b0;
            end
            default: begin
                pc_nx     = pcsel;
                dpc4_nx   = pc4;
                dinst_nx  = ins;
                dvalid_nx = 1'b1;
            end
        endcase
    end

    // PC, IF/ID and epc registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            epc    <= 32'h0;
            dpc4   <= 32'h0;
            dinst  <= 32'h0;
            dvalid <= 1'b0;
        end else begin
            pc     <= pc_nx;
            epc    <= epc_nx;
            dpc4   <= dpc4_nx;
            dinst  <= dinst_nx;
            dvalid <= dvalid_nx;
        end
    end

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// Bench for pipe_fetch_ctrl: reference model checked every negedge
// plus directed scenarios with hand-computed literals.
module tb_pipe_fetch_ctrl;

    localparam logic [31:0] VEC = 32'h0000_0008;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'h0;
    logic [31:0] rpc = 32'h0;
    logic [31:0] jpc = 32'h0;
    logic [31:0] ins;
    logic        intr = 1'b0;
    logic        inten = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] pc;
    logic [31:0] dpc4;
    logic [31:0] dinst;
    logic        dvalid;
    logic [31:0] epc;
    logic        inta;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;
    int n_inta = 0;
    int snap;

    pipe_fetch_ctrl #(.VECTOR(VEC), .RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .pcsource(pcsource), .bpc(bpc), .rpc(rpc), .jpc(jpc),
        .ins(ins), .intr(intr), .inten(inten), .eret(eret),
        .pc(pc), .dpc4(dpc4), .dinst(dinst), .dvalid(dvalid),
        .epc(epc), .inta(inta), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign ins = imem(pc);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = running, 1 = waiting, 2 = taking.
    logic [31:0] m_pc, m_epc, m_dpc4, m_dinst;
    logic        m_dvalid;
    int          m_ph;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_pc = RPC; m_epc = 0; m_dpc4 = 0; m_dinst = 0;
            m_dvalid = 0; m_ph = 0;
        end else begin
            automatic bit want = intr && inten;
            automatic bit calm = !stall && pcsource == 2'b00 && !eret;
            automatic int old = m_ph;
            if (old == 2) begin
                m_epc = m_pc; m_pc = VEC;
                m_dpc4 = 0; m_dinst = 0; m_dvalid = 0;
            end else if (stall) begin
                m_pc = m_pc;
            end else if (eret) begin
                m_pc = m_epc;
                m_dpc4 = 0; m_dinst = 0; m_dvalid = 0;
            end else begin
                m_dpc4 = m_pc + 32'd4;
                m_dinst = imem(m_pc);
                m_dvalid = 1;
                case (pcsource)
                    2'b00: m_pc = m_pc + 32'd4;
                    2'b01: m_pc = bpc;
                    2'b10: m_pc = rpc;
                    default: m_pc = jpc;
                endcase
            end
            if (old == 0) m_ph = want ? 1 : 0;
            else if (old == 1) m_ph = !want ? 0 : (calm ? 2 : 1);
            else m_ph = 0;
        end
    end

    // Compare DUT against the model away from the active edge.
    always @(negedge clock) begin
        chk("m_pc", pc, m_pc);
        chk("m_epc", epc, m_epc);
        chk("m_dpc4", dpc4, m_dpc4);
        chk("m_dinst", dinst, m_dinst);
        chk("m_dvalid", {31'b0, dvalid}, {31'b0, m_dvalid});
        chk("m_inta", {31'b0, inta}, {31'b0, m_ph == 2});
        chk("m_busy", {31'b0, busy}, {31'b0, m_ph != 0});
        if (inta) n_inta++;
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_dvalid", {31'b0, dvalid}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        #1 reset = 1'b0;

        tick();
        chk("seq1_pc", pc, 32'h4);
        chk("seq1_dpc4", dpc4, 32'h4);
        chk("seq1_dvalid", {31'b0, dvalid}, 32'h1);
        tick();
        chk("seq2_pc", pc, 32'h8);
        chk("seq2_dpc4", dpc4, 32'h8);
        tick();
        chk("seq3_pc", pc, 32'hC);
        chk("seq3_dpc4", dpc4, 32'hC);

        pcsource = 2'b11; jpc = 32'h20;
        tick();
        chk("jmp_pc", pc, 32'h20);
        pcsource = 2'b01; bpc = 32'h100;
        tick();
        chk("br_pc", pc, 32'h100);
        chk("br_dpc4", dpc4, 32'h24);
        pcsource = 2'b11; jpc = 32'h20;
        tick();
        stall = 1'b1; pcsource = 2'b01;
        tick();
        chk("stall_pc", pc, 32'h20);
        chk("stall_dpc4", dpc4, 32'h104);
        chk("stall_dinst", dinst, imem(32'h100));
        stall = 1'b0; pcsource = 2'b10; rpc = 32'h40;
        tick();
        chk("rj_pc", pc, 32'h40);

        intr = 1'b1; inten = 1'b1; pcsource = 2'b00;
        tick();
        chk("irq_pend_busy", {31'b0, busy}, 32'h1);
        chk("irq_pend_pc", pc, 32'h44);
        pcsource = 2'b11; jpc = 32'h80;
        tick();
        chk("irq_wait_inta", {31'b0, inta}, 32'h0);
        chk("irq_wait_pc", pc, 32'h80);
        pcsource = 2'b00;
        tick();
        chk("irq_take_inta", {31'b0, inta}, 32'h1);
        chk("irq_take_pc", pc, 32'h84);
        intr = 1'b0;
        tick();
        chk("irq_vec_pc", pc, 32'h8);
        chk("irq_epc", epc, 32'h84);
        chk("irq_flush", {31'b0, dvalid}, 32'h0);
        chk("irq_flush_inst", dinst, 32'h0);
        chk("irq_done_inta", {31'b0, inta}, 32'h0);

        snap = n_inta;
        intr = 1'b1; inten = 1'b0;
        repeat (10) tick();
        chk("mask_pc", pc, 32'h30);
        chk("mask_inta", n_inta, snap);
        intr = 1'b0;

        pcsource = 2'b11; jpc = 32'h3C;
        tick();
        pcsource = 2'b00; intr = 1'b1; inten = 1'b1;
        tick();
        tick();
        intr = 1'b0;
        tick();
        chk("epc44", epc, 32'h44);
        tick();
        chk("pre_eret_pc", pc, 32'hC);
        eret = 1'b1; stall = 1'b1;
        tick();
        chk("eret_stall_pc", pc, 32'hC);
        chk("eret_stall_dv", {31'b0, dvalid}, 32'h1);
        stall = 1'b0;
        tick();
        chk("eret_pc", pc, 32'h44);
        chk("eret_dv", {31'b0, dvalid}, 32'h0);
        chk("eret_epc", epc, 32'h44);
        eret = 1'b0;

        snap = n_inta;
        intr = 1'b1; stall = 1'b1;
        tick();
        chk("drop_pend", {31'b0, busy}, 32'h1);
        intr = 1'b0;
        tick();
        chk("drop_run", {31'b0, busy}, 32'h0);
        chk("drop_pc", pc, 32'h44);
        chk("drop_inta", n_inta, snap);
        stall = 1'b0;

        intr = 1'b1;
        repeat (6) tick();
        intr = 1'b0;
        tick();
        tick();

        intr = 1'b1;
        tick();
        tick();
        intr = 1'b0;
        chk("mid_inta", {31'b0, inta}, 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("ar_pc", pc, RPC);
        chk("ar_epc", epc, 32'h0);
        chk("ar_dpc4", dpc4, 32'h0);
        chk("ar_dinst", dinst, 32'h0);
        chk("ar_dvalid", {31'b0, dvalid}, 32'h0);
        chk("ar_inta", {31'b0, inta}, 32'h0);
        chk("ar_busy", {31'b0, busy}, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_dpc4", dpc4, 32'h4);
        chk("post_rst_dinst", dinst, imem(32'h0));
        chk("post_rst_epc", epc, 32'h0);

        pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
        tick();
        pcsource = 2'b00;
        tick();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_dpc4", dpc4, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
